// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: one-entry holding register feeding a start/data/stop shifter.
// Optional parity symbol between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_framed #(
   parameter int unsigned CLOCK_FREQ = 125_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
`ifdef UART_TX_PARITY_EN
   input  logic       parity_odd,
`endif
   output logic       data_in_ready,
   output logic       serial_out,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned SYMBOL_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned SymW = (SYMBOL_TIME > 1) ? $clog2(SYMBOL_TIME) : 1;
   localparam logic [SymW-1:0] SymLast = SymW'(SYMBOL_TIME - 1);
   localparam logic [2:0] DataLast = 3'(DATA_BITS - 1);
   localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
   localparam logic [7:0] DataMask = 8'hFF >> (8 - DATA_BITS);
`endif

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e            state_q, state_d;
   logic [SymW-1:0]   sym_cnt_q, sym_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [7:0]        shift_q, shift_d;
   logic              serial_q, serial_d;
   logic              sym_end, fire, load;
`ifdef UART_TX_PARITY_EN
   logic              par_hold_q, par_hold_d;
   logic              par_q, par_d;
`endif

   assign sym_end = (sym_cnt_q == SymLast);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (hold_full_q) state_d = StStart;
         StStart: if (sym_end) state_d = StData;
`ifdef UART_TX_PARITY_EN
         StData:   if (sym_end && bit_cnt_q == DataLast) state_d = StParity;
         StParity: if (sym_end) state_d = StStop;
`else
         StData:  if (sym_end && bit_cnt_q == DataLast) state_d = StStop;
`endif
         // Back-to-back frames: a held byte goes straight into a new start bit.
         StStop:  if (sym_end && bit_cnt_q == StopLast) state_d = hold_full_q ? StStart : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath: holding register, shifter and symbol/bit counters.
   always_comb begin
      fire        = data_in_valid && !hold_full_q;
      load        = hold_full_q && (state_d == StStart) && (state_q != StStart);
      hold_d      = fire ? data_in : hold_q;
      hold_full_d = fire || (hold_full_q && !load);
      shift_d     = shift_q;
      if (load) begin
         shift_d = hold_q;
      end else if (state_q == StData && sym_end) begin
         shift_d = shift_q >> 1;
      end
      if (state_d != state_q || sym_end || state_q == StIdle) begin
         sym_cnt_d = '0;
      end else begin
         sym_cnt_d = sym_cnt_q + 1'b1;
      end
      bit_cnt_d = bit_cnt_q;
      if (state_d != state_q) begin
         bit_cnt_d = '0;
      end else if (sym_end && (state_q == StData || state_q == StStop)) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
      end
`ifdef UART_TX_PARITY_EN
      par_hold_d = fire ? parity_odd : par_hold_q;
      par_d      = load ? ((^(hold_q & DataMask)) ^ par_hold_q) : par_q;
`endif
   end

   always_comb begin
      data_in_ready = !hold_full_q;
      busy          = (state_q != StIdle);
      frame_done    = (state_q == StStop) && sym_end && (bit_cnt_q == StopLast);
      // Line value is computed from the next state so serial_out is a clean register.
      case (state_d)
         StStart:  serial_d = 1'b0;
         StData:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: serial_d = par_d;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sym_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         serial_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_hold_q  <= 1'b0;
         par_q       <= 1'b0;
`endif
      end else begin
         sym_cnt_q   <= sym_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         serial_q    <= serial_d;
`ifdef UART_TX_PARITY_EN
         par_hold_q  <= par_hold_d;
         par_q       <= par_d;
`endif
      end
   end

   assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed: expected line bits queued at stimulus, compared per cycle.
// Two instances: 8N1 and 7 data / 2 stop bits; parity test built when UART_TX_PARITY_EN is set.
module tb_uart_tx_framed;

   localparam int CF = 1000;
   localparam int BR = 100;
   localparam int ST = CF / BR;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = '0;
   logic       data_in_valid = 1'b0;
   logic       parity_odd = 1'b0;
   logic       data_in_ready, serial_out, busy, frame_done;
   logic [7:0] data_in7 = '0;
   logic       data_in_valid7 = 1'b0;
   logic       parity_odd7 = 1'b0;
   logic       data_in_ready7, serial_out7, busy7, frame_done7;

   int   n_checks = 0;
   int   n_pass = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   uart_tx_framed #(
      .CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .data_in_valid(data_in_valid),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .data_in_ready(data_in_ready),
      .serial_out(serial_out),
      .busy(busy),
      .frame_done(frame_done)
   );

   uart_tx_framed #(
      .CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .STOP_BITS(2)
   ) dut7 (
      .clk(clk),
      .reset(reset),
      .data_in(data_in7),
      .data_in_valid(data_in_valid7),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd7),
`endif
      .data_in_ready(data_in_ready7),
      .serial_out(serial_out7),
      .busy(busy7),
      .frame_done(frame_done7)
   );

   function automatic int flen(input int nb, input int ns);
      return (1 + nb + PAR + ns) * ST;
   endfunction

   // Reference frame model: one queue entry per symbol.
   task automatic push_frame(input logic [7:0] d, input int nb, input int ns, input logic podd);
      logic p;
      p = podd;
      exp_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(d[i]);
         p = p ^ d[i];
      end
      if (PAR != 0) exp_q.push_back(p);
      for (int i = 0; i < ns; i++) exp_q.push_back(1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({serial_out, data_in_ready, busy, frame_done} !== 4'b1100)
         $display("FAIL reset_8n1: got %b want 1100", {serial_out, data_in_ready, busy, frame_done});
      else n_pass++;
      n_checks++;
      if ({serial_out7, data_in_ready7, busy7, frame_done7} !== 4'b1100)
         $display("FAIL reset_7n2: got %b want 1100",
                  {serial_out7, data_in_ready7, busy7, frame_done7});
      else n_pass++;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({serial_out, busy, serial_out7, busy7} !== 4'b1010)
         $display("FAIL reset_idle: got %b want 1010", {serial_out, busy, serial_out7, busy7});
      else n_pass++;
   endtask

   task automatic test_basic();
      int   fl, n_fd;
      logic cur;
      fl = flen(8, 1);
      n_fd = 0;
      cur = 1'b1;
      push_frame(8'hA5, 8, 1, 1'b0);
      data_in = 8'hA5;
      parity_odd = 1'b0;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      n_checks++;
      if ({serial_out, data_in_ready, busy} !== 3'b100)
         $display("FAIL basic_accept: got %b want 100", {serial_out, data_in_ready, busy});
      else n_pass++;
      for (int k = 0; k < fl; k++) begin
         @(negedge clk);
         if (k % ST == 0) begin
            if (exp_q.size() == 0) cur = 1'bx;
            else cur = exp_q.pop_front();
         end
         n_checks++;
         if (serial_out !== cur) $display("FAIL basic_line[%0d]: got %b want %b", k, serial_out, cur);
         else n_pass++;
         n_checks++;
         if ({busy, frame_done} !== {1'b1, k == fl - 1})
            $display("FAIL basic_busy_done[%0d]: got %b want %b", k, {busy, frame_done},
                     {1'b1, k == fl - 1});
         else n_pass++;
         if (frame_done === 1'b1) n_fd++;
      end
      @(negedge clk);
      n_checks++;
      if ({serial_out, data_in_ready, busy, frame_done} !== 4'b1100)
         $display("FAIL basic_idle: got %b want 1100",
                  {serial_out, data_in_ready, busy, frame_done});
      else n_pass++;
      n_checks++;
      if (n_fd != 1) $display("FAIL basic_done_count: got %0d want 1", n_fd);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int   fl;
      logic cur, rdy_exp;
      fl = flen(8, 1);
      cur = 1'b1;
      push_frame(8'h55, 8, 1, 1'b0);
      data_in = 8'h55;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      n_checks++;
      if (data_in_ready !== 1'b0) $display("FAIL b2b_held: got %b want 0", data_in_ready);
      else n_pass++;
      for (int k = 0; k < 2 * fl; k++) begin
         @(negedge clk);
         if (k == 0) begin
            push_frame(8'h0F, 8, 1, 1'b0);
            data_in = 8'h0F;
            data_in_valid = 1'b1;
         end else if (k == 1) begin
            data_in_valid = 1'b0;
         end
         if (k % ST == 0) begin
            if (exp_q.size() == 0) cur = 1'bx;
            else cur = exp_q.pop_front();
         end
         rdy_exp = (k == 0) || (k >= fl);
         n_checks++;
         if (serial_out !== cur) $display("FAIL b2b_line[%0d]: got %b want %b", k, serial_out, cur);
         else n_pass++;
         n_checks++;
         if ({busy, data_in_ready, frame_done} !== {1'b1, rdy_exp, (k == fl - 1) || (k == 2 * fl - 1)})
            $display("FAIL b2b_ctrl[%0d]: got %b want %b", k, {busy, data_in_ready, frame_done},
                     {1'b1, rdy_exp, (k == fl - 1) || (k == 2 * fl - 1)});
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if ({serial_out, busy, exp_q.size() == 0} !== 3'b101)
         $display("FAIL b2b_end: got %b want 101", {serial_out, busy, exp_q.size() == 0});
      else n_pass++;
   endtask

   task automatic test_short_frame();
      logic [7:0] bytes[2];
      int         fl;
      logic       cur;
      bytes[0] = 8'hFF;
      bytes[1] = 8'h80;
      fl = flen(7, 2);
      cur = 1'b1;
      for (int b = 0; b < 2; b++) begin
         push_frame(bytes[b], 7, 2, 1'b0);
         data_in7 = bytes[b];
         data_in_valid7 = 1'b1;
         @(negedge clk);
         data_in_valid7 = 1'b0;
         for (int k = 0; k < fl; k++) begin
            @(negedge clk);
            if (k % ST == 0) begin
               if (exp_q.size() == 0) cur = 1'bx;
               else cur = exp_q.pop_front();
            end
            n_checks++;
            if (serial_out7 !== cur)
               $display("FAIL short_line[%0d][%0d]: got %b want %b", b, k, serial_out7, cur);
            else n_pass++;
            n_checks++;
            if ({busy7, frame_done7} !== {1'b1, k == fl - 1})
               $display("FAIL short_busy_done[%0d][%0d]: got %b want %b", b, k,
                        {busy7, frame_done7}, {1'b1, k == fl - 1});
            else n_pass++;
         end
         @(negedge clk);
         n_checks++;
         if ({serial_out7, busy7, data_in_ready7} !== 3'b101)
            $display("FAIL short_idle[%0d]: got %b want 101", b,
                     {serial_out7, busy7, data_in_ready7});
         else n_pass++;
         repeat (2) @(negedge clk);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int   fl, pk;
      logic cur, pexp;
      fl = flen(8, 1);
      pk = 9 * ST + ST / 2;
      cur = 1'b1;
      for (int po = 0; po < 2; po++) begin
         pexp = (po == 0) ? 1'b1 : 1'b0;
         push_frame(8'h07, 8, 1, po[0]);
         data_in = 8'h07;
         parity_odd = po[0];
         data_in_valid = 1'b1;
         @(negedge clk);
         data_in_valid = 1'b0;
         parity_odd = ~po[0];
         for (int k = 0; k < fl; k++) begin
            @(negedge clk);
            if (k % ST == 0) begin
               if (exp_q.size() == 0) cur = 1'bx;
               else cur = exp_q.pop_front();
            end
            n_checks++;
            if (serial_out !== cur)
               $display("FAIL parity_line[%0d][%0d]: got %b want %b", po, k, serial_out, cur);
            else n_pass++;
            if (k == pk) begin
               n_checks++;
               if (serial_out !== pexp)
                  $display("FAIL parity_bit[%0d]: got %b want %b", po, serial_out, pexp);
               else n_pass++;
            end
         end
         repeat (2) @(negedge clk);
      end
   endtask
`endif

   task automatic test_reset_mid();
      int kr, lows, n_fd, n_busy;
      kr = 4 * ST + 5;
      lows = 0;
      n_fd = 0;
      n_busy = 0;
      data_in = 8'hA5;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      for (int k = 0; k <= kr; k++) begin
         @(negedge clk);
         if (k == 2) begin
            data_in = 8'h3C;
            data_in_valid = 1'b1;
         end else if (k == 3) begin
            data_in_valid = 1'b0;
         end
      end
      n_checks++;
      if ({serial_out, data_in_ready} !== 2'b00)
         $display("FAIL rstmid_pre: got %b want 00", {serial_out, data_in_ready});
      else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({serial_out, busy, data_in_ready, frame_done} !== 4'b1010)
         $display("FAIL rstmid_abort: got %b want 1010",
                  {serial_out, busy, data_in_ready, frame_done});
      else n_pass++;
      reset = 1'b0;
      for (int k = 0; k < 3 * flen(8, 1); k++) begin
         @(negedge clk);
         if (serial_out !== 1'b1) lows++;
         if (frame_done !== 1'b0) n_fd++;
         if (busy !== 1'b0) n_busy++;
      end
      n_checks++;
      if (lows != 0 || n_busy != 0)
         $display("FAIL rstmid_discard: got lows=%0d busy=%0d want 0/0", lows, n_busy);
      else n_pass++;
      n_checks++;
      if (n_fd != 0) $display("FAIL rstmid_no_done: got %0d want 0", n_fd);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      repeat (3) @(negedge clk);
      test_back_to_back();
      repeat (3) @(negedge clk);
      test_short_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
- REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, meaning input clock frequency in Hz.
- REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line bit rate; SYMBOL_TIME = CLOCK_FREQ/BAUD_RATE cycles, integer division.
- REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal values 5..8.
- REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
- REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
- REQ-006 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
- REQ-007 SHALL have port data_in, input, 8 bits, meaning the payload; only bits [DATA_BITS-1:0] are sent.
- REQ-008 SHALL have port data_in_valid, input, 1 bit, meaning data_in is offered.
- REQ-009 SHALL have port data_in_ready, output, 1 bit, meaning the holding register is empty.
- REQ-010 SHALL have port serial_out, output, 1 bit, meaning the TX line; idle high.
- REQ-011 SHALL have port busy, output, 1 bit, meaning a frame is on the line (state != IDLE).
- REQ-012 SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse in the last cycle of the final stop bit.

Function
- REQ-013 SHALL accept a byte on the cycle data_in_valid && data_in_ready (fire), latching it into a one-entry holding register.
- REQ-014 SHALL drive data_in_ready = holding register empty; it depends on no input combinationally.
- REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
- REQ-016 SHALL leave IDLE when the holding register is full: move the byte into the shift register, empty the holding register, enter START.
- REQ-017 SHALL drive serial_out low for exactly SYMBOL_TIME cycles in START, then each data bit LSB-first for SYMBOL_TIME cycles in DATA, then high for STOP_BITS*SYMBOL_TIME cycles in STOP.
- REQ-018 SHALL use a symbol counter that resets to 0 on every state change and at each symbol boundary (count == SYMBOL_TIME-1).
- REQ-019 SHALL use a bit counter that advances DATA to the next state after DATA_BITS symbols and advances STOP after STOP_BITS symbols.
- REQ-020 SHALL place the first cycle of START on the cycle after the IDLE-to-START transition; latency from fire in IDLE with the holding register empty to the first low on serial_out is 2 cycles.
- REQ-021 SHALL leave STOP at the end of the final stop bit: go to START when the holding register is full (no idle gap between frames), else to IDLE.
- REQ-022 SHALL accept a new byte while a frame is in progress when the holding register is empty; this byte is the next frame.
- REQ-023 SHALL give simultaneous fire and hold-to-shift transfer in the same cycle correct ordering: the transfer uses the old holding value and the new byte stays held.
- REQ-024 SHALL never glitch serial_out; it is a registered output.

Reset
- REQ-025 SHALL, on reset, set state to IDLE, empty the holding register, and clear both counters.
- REQ-026 SHALL, on reset, set serial_out=1, data_in_ready=1, busy=0, frame_done=0.
- REQ-027 SHALL, when reset is asserted mid-frame, abort the frame and return serial_out high on the next edge; the aborted and held bytes are discarded.

Configuration
- REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, add input parity_odd (1 bit) and send a PARITY state of one symbol between DATA and STOP.
- REQ-029 SHALL, with UART_TX_PARITY_EN defined, set the parity bit to XOR of the sent data bits, XOR parity_odd; parity_odd is sampled at fire and stored with the byte.
- REQ-030 SHALL, without UART_TX_PARITY_EN, have no parity_odd port, no PARITY state, and the frame length 1+DATA_BITS+STOP_BITS symbols.

Verification
- REQ-031 SHALL cover: CLOCK_FREQ=1000, BAUD_RATE=100, fire 8'hA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; frame_done pulses once at cycle 100 of the frame.
- REQ-032 SHALL cover: fire 8'h55 then 8'h0F on the next cycle data_in_ready=1 -> second start bit directly follows the first stop bit, no idle cycles; data_in_ready stays 0 while held.
- REQ-033 SHALL cover: DATA_BITS=7, STOP_BITS=2, send 8'hFF -> 7 ones sent, bit 7 ignored, line high for 2 symbols, frame = 10 symbols.
- REQ-034 SHALL cover: UART_TX_PARITY_EN, parity_odd=0, byte 8'h07 -> parity bit 1; parity_odd=1 -> parity bit 0.
- REQ-035 SHALL cover: reset asserted during DATA bit 3 -> next cycle serial_out=1, busy=0, data_in_ready=1, no frame_done.
